// File: rtl/alu_result_stage.sv
// alu_result_stage
//   Registered output stage behind the ALU bitwise/adder units. Selects the
//   unit result for the opcode, computes status flags, and presents result +
//   flags on a valid/ready interface through a two-entry skid buffer (OUT and
//   SKID) so that in_ready is a plain flop. Also keeps a saturating count of
//   accepted transactions.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake (in_ready registered)
//   op                    000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, else illegal
//   and_in .. add_in      unit results, WIDTH bits each
//   add_cout              adder carry-out
//   out_valid / out_ready downstream handshake
//   result                selected result (registered)
//   flag_z/n/c/p/err      zero, negative, carry, odd parity, illegal opcode
//   op_count              saturating count of accepted transactions
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] and_in,
  input  logic [WIDTH-1:0] or_in,
  input  logic [WIDTH-1:0] xor_in,
  input  logic [WIDTH-1:0] add_in,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_p,
  output logic             flag_err,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOR = 3'b011,
    OP_ADD = 3'b100
  } op_e;

  // EMPTY: nothing held; ONE: OUT full; TWO: OUT and SKID full.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // Result and flags travel together so they can never skew by a cycle.
  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             n;
    logic             c;
    logic             p;
    logic             err;
  } entry_t;

  state_e           state;
  entry_t           out_entry;
  entry_t           skid_entry;
  entry_t           new_entry;
  logic [WIDTH-1:0] sel_result;
  logic             sel_err;
  logic             ready_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  assign accept = in_valid && ready_q;

  // Result selection and flag generation for the incoming transaction.
  // NOTE: every always_comb output gets a default before the case so no
  // opcode path can leave it unassigned and infer a latch.
  always_comb begin
    sel_result = '0;
    sel_err    = 1'b0;
    case (op)
      OP_AND:  sel_result = and_in;
      OP_OR:   sel_result = or_in;
      OP_XOR:  sel_result = xor_in;
      OP_NOR:  sel_result = ~or_in;
      OP_ADD:  sel_result = add_in;
      default: sel_err    = 1'b1;
    endcase
  end

  always_comb begin
    new_entry.res = sel_result;
    new_entry.z   = ~|sel_result;
    new_entry.n   = sel_result[WIDTH-1];
    // Illegal opcodes never select ADD, so carry is zero for them too.
    new_entry.c   = (op == OP_ADD) && add_cout;
    new_entry.p   = ^sel_result;
    new_entry.err = sel_err;
  end

  // Skid-buffer control, data registers and operation counter.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values and ordering inside the block does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      out_entry  <= '0;
      // NOTE: SKID is only two words, so it is reset along with OUT; this
      // keeps a flushed stage free of stale data rather than relying on the
      // state machine to hide it.
      skid_entry <= '0;
      cnt_q      <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_entry <= new_entry;
            valid_q   <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (out_ready && accept) begin
            out_entry <= new_entry;
          end else if (out_ready) begin
            valid_q <= 1'b0;
            state   <= EMPTY;
          end else if (accept) begin
            // Downstream stalled: park the newcomer and close the input.
            skid_entry <= new_entry;
            ready_q    <= 1'b0;
            state      <= TWO;
          end
        end
        TWO: begin
          if (out_ready) begin
            out_entry <= skid_entry;
            ready_q   <= 1'b1;
            state     <= ONE;
          end
        end
        default: begin
          state   <= EMPTY;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase

      if (accept && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign result    = out_entry.res;
  assign flag_z    = out_entry.z;
  assign flag_n    = out_entry.n;
  assign flag_c    = out_entry.c;
  assign flag_p    = out_entry.p;
  assign flag_err  = out_entry.err;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage
//   Directed bench for alu_result_stage: reset values, opcode sweep,
//   back-pressure ordering, hold stability, randomised stall run against a
//   queue model, mid-transfer asynchronous reset, and counter saturation on a
//   second instance built with CNT_W=4.
module tb_alu_result_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] and_in;
  logic [31:0] or_in;
  logic [31:0] xor_in;
  logic [31:0] add_in;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_z;
  logic        flag_n;
  logic        flag_c;
  logic        flag_p;
  logic        flag_err;
  logic [15:0] op_count;

  // Saturation instance signals.
  logic        rst_n_s;
  logic        in_valid_s;
  logic        in_ready_s;
  logic        out_valid_s;
  logic        out_ready_s;
  logic [31:0] result_s;
  logic        flag_z_s;
  logic        flag_n_s;
  logic        flag_c_s;
  logic        flag_p_s;
  logic        flag_err_s;
  logic [3:0]  op_count_s;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [36:0] q[$];

  logic [36:0] obs_e;
  assign obs_e = {result, flag_z, flag_n, flag_c, flag_p, flag_err};

  alu_result_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .and_in(and_in), .or_in(or_in), .xor_in(xor_in),
    .add_in(add_in), .add_cout(add_cout), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flag_z(flag_z),
    .flag_n(flag_n), .flag_c(flag_c), .flag_p(flag_p),
    .flag_err(flag_err), .op_count(op_count)
  );

  alu_result_stage #(.WIDTH(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .op(op), .and_in(and_in), .or_in(or_in), .xor_in(xor_in),
    .add_in(add_in), .add_cout(add_cout), .out_valid(out_valid_s),
    .out_ready(out_ready_s), .result(result_s), .flag_z(flag_z_s),
    .flag_n(flag_n_s), .flag_c(flag_c_s), .flag_p(flag_p_s),
    .flag_err(flag_err_s), .op_count(op_count_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference entry {result, z, n, c, p, err} for the current bench inputs.
  function automatic logic [36:0] model(input logic [2:0] o);
    logic [31:0] r;
    logic        e;
    r = '0;
    e = 1'b0;
    case (o)
      3'd0:    r = and_in;
      3'd1:    r = or_in;
      3'd2:    r = xor_in;
      3'd3:    r = ~or_in;
      3'd4:    r = add_in;
      default: e = 1'b1;
    endcase
    return {r, (r == 32'd0), r[31], (o == 3'd4) && add_cout, ^r, e};
  endfunction

  // One sweep transfer with out_ready=1; returns at the following negedge.
  task automatic xfer(input logic [2:0] o);
    op = o;
    in_valid = 1'b1;
    check("sweep_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    exp_cnt++;
  endtask

  // One cycle of the random run: compare DUT against the queue model, then
  // drive random stimulus and advance the model by the handshakes it implies.
  task automatic rnd_cycle(input bit allow_in);
    bit vld_m;
    bit rdy_m;
    vld_m = (q.size() != 0);
    rdy_m = (q.size() < 2);
    check("rnd_out_valid", 64'(out_valid), 64'(vld_m));
    check("rnd_in_ready", 64'(in_ready), 64'(rdy_m));
    if (vld_m) check("rnd_data", 64'(obs_e), 64'(q[0]));
    in_valid  = allow_in ? ($urandom_range(0, 1) == 1) : 1'b0;
    out_ready = allow_in ? ($urandom_range(0, 1) == 1) : 1'b1;
    op        = 3'($urandom_range(0, 7));
    and_in    = $urandom;
    or_in     = $urandom;
    xor_in    = $urandom;
    add_in    = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
    add_cout  = ($urandom_range(0, 1) == 1);
    if (vld_m && out_ready) void'(q.pop_front());
    if (in_valid && rdy_m) begin
      q.push_back(model(op));
      exp_cnt++;
    end
    @(negedge clk);
  endtask

  logic [31:0] bp_vals [4];
  int idx;
  int k;

  initial begin
    rst_n = 1'b0;
    rst_n_s = 1'b0;
    in_valid = 1'b0;
    in_valid_s = 1'b0;
    out_ready = 1'b1;
    out_ready_s = 1'b1;
    op = 3'd0;
    and_in = '0;
    or_in = '0;
    xor_in = '0;
    add_in = '0;
    add_cout = 1'b0;
    bp_vals[0] = 32'h0000_0011;
    bp_vals[1] = 32'h0000_0022;
    bp_vals[2] = 32'h0000_0033;
    bp_vals[3] = 32'h0000_0044;

    // ---- Reset state
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_entry", 64'(obs_e), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rst_n_s = 1'b1;

    // ---- Opcode sweep
    and_in = 32'h0000_00F0;
    or_in = 32'hFFFF_00FF;
    xor_in = 32'h0000_0001;
    add_in = 32'h0000_0000;
    add_cout = 1'b1;
    out_ready = 1'b1;
    xfer(3'd0);
    check("sweep_and", 64'(obs_e), 64'({32'h0000_00F0, 5'b00000}));
    check("sweep_and_valid", 64'(out_valid), 64'd1);
    xfer(3'd1);
    check("sweep_or", 64'(obs_e), 64'({32'hFFFF_00FF, 5'b01000}));
    xfer(3'd2);
    check("sweep_xor", 64'(obs_e), 64'({32'h0000_0001, 5'b00010}));
    xfer(3'd3);
    check("sweep_nor", 64'(obs_e), 64'({32'h0000_FF00, 5'b00000}));
    xfer(3'd4);
    check("sweep_add", 64'(obs_e), 64'({32'h0000_0000, 5'b10100}));
    xfer(3'd7);
    check("sweep_illegal", 64'(obs_e), 64'({32'h0000_0000, 5'b10001}));
    check("sweep_count", 64'(op_count), 64'd6);
    @(negedge clk);
    check("sweep_drained", 64'(out_valid), 64'd0);

    // ---- Back-pressure: out_ready low for the first four cycles
    idx = 0;
    k = 0;
    op = 3'd2;
    for (int cyc = 0; cyc < 30 && k < 4; cyc++) begin
      if (cyc == 4) begin
        check("bp_accepted", 64'(idx), 64'd2);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_held_out", 64'(result), 64'(bp_vals[0]));
      end
      out_ready = (cyc >= 4);
      in_valid = (idx < 4);
      xor_in = bp_vals[(idx < 4) ? idx : 0];
      if (out_valid && out_ready) begin
        check("bp_order", 64'(result), 64'(bp_vals[k]));
        k++;
      end
      if (in_valid && in_ready) begin
        idx++;
        exp_cnt++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_all_out", 64'(k), 64'd4);
    check("bp_all_in", 64'(idx), 64'd4);
    check("bp_empty", 64'(out_valid), 64'd0);
    check("bp_count", 64'(op_count), 64'(exp_cnt));

    // ---- Hold stability under toggling inputs
    out_ready = 1'b0;
    op = 3'd4;
    add_in = 32'h8000_0001;
    add_cout = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    exp_cnt++;
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_entry", 64'(obs_e), 64'({32'h8000_0001, 5'b01100}));
      op = 3'($urandom_range(0, 7));
      and_in = $urandom;
      or_in = $urandom;
      xor_in = $urandom;
      add_in = $urandom;
      add_cout = ~add_cout;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_drained", 64'(out_valid), 64'd0);

    // ---- Random stalls against the queue model
    for (int i = 0; i < 1000; i++) rnd_cycle(1'b1);
    for (int i = 0; i < 4; i++) rnd_cycle(1'b0);
    check("rnd_queue_empty", 64'(q.size()), 64'd0);
    check("rnd_count", 64'(op_count), 64'(exp_cnt));

    // ---- Asynchronous reset mid-cycle while in TWO
    out_ready = 1'b0;
    op = 3'd2;
    in_valid = 1'b1;
    xor_in = 32'h0000_0001;
    @(negedge clk);
    xor_in = 32'h0000_0002;
    @(negedge clk);
    in_valid = 1'b0;
    check("flush_two_full", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_count", 64'(op_count), 64'd0);
    check("flush_entry", 64'(obs_e), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    xor_in = 32'h0000_005A;
    @(negedge clk);
    in_valid = 1'b0;
    check("post_flush_entry", 64'(obs_e), 64'({32'h0000_005A, 5'b00000}));
    check("post_flush_count", 64'(op_count), 64'd1);
    @(negedge clk);
    check("post_flush_no_stale", 64'(out_valid), 64'd0);

    // ---- Counter saturation on the CNT_W=4 instance
    check("sat_start", 64'(op_count_s), 64'd0);
    for (int i = 1; i <= 20; i++) begin
      in_valid_s = 1'b1;
      check("sat_in_ready", 64'(in_ready_s), 64'd1);
      @(negedge clk);
      if (i == 14) check("sat_14", 64'(op_count_s), 64'd14);
      if (i == 15) check("sat_15", 64'(op_count_s), 64'd15);
    end
    in_valid_s = 1'b0;
    check("sat_hold", 64'(op_count_s), 64'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage that sits directly downstream of the ALU's bitwise and adder units, including the n-bit OR unit. Each cycle it can accept one transaction: an opcode plus all unit results. It selects the result for that opcode and computes status flags. It presents the result on a valid/ready interface, backed by a two-entry skid buffer so `in_ready` comes straight from a flop. It also keeps a saturating count of accepted operations.

## Interface
- `WIDTH`, 32, datapath width of every result bus
- `CNT_W`, 16, width of the operation counter
- `clk` input 1, sole clock; all state updates on rising edge
- `rst_n` input 1, asynchronous active-low reset
- `in_valid` input 1, upstream transaction valid
- `in_ready` output 1, stage can accept; driven directly by a flop
- `op` input 3, opcode: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD; 101-111 illegal
- `and_in`, `or_in`, `xor_in`, `add_in` input WIDTH each, unit results
- `add_cout` input 1, adder carry-out
- `out_valid` output 1, result register holds a transaction
- `out_ready` input 1, downstream accepts
- `result` output WIDTH, selected result
- `flag_z` output 1, result == 0
- `flag_n` output 1, result[WIDTH-1]
- `flag_c` output 1, `add_cout` for ADD, else 0
- `flag_p` output 1, XOR-reduction of result (1 = odd number of ones)
- `flag_err` output 1, opcode illegal
- `op_count` output CNT_W, accepted transactions, saturating

## Operation
- Accept: a transaction is accepted when `in_valid && in_ready` at the rising edge.
- Result selection by `op`:
  - AND → `and_in`
  - OR → `or_in`
  - XOR → `xor_in`
  - NOR → `~or_in`
  - ADD → `add_in`
  - illegal → all-zero result with `flag_err`=1. This gives `flag_z`=1, `flag_c`=0, `flag_n`=0, `flag_p`=0.
- Flags are computed from the selected result before registering. Result and flags travel together as one entry of WIDTH+5 bits.
- Storage: output register (OUT) plus one skid register (SKID).
- State machine:
  - EMPTY: `out_valid`=0. Accept → OUT loaded, go to ONE.
  - ONE: OUT valid, SKID empty.
    - `out_ready` and accept → OUT reloaded, stay in ONE.
    - `out_ready`, no accept → EMPTY.
    - No `out_ready` and accept → SKID loaded, go to TWO.
    - Otherwise hold.
  - TWO: both full, `in_ready`=0.
    - `out_ready` → SKID moves to OUT, go to ONE.
    - Otherwise hold.
- `in_ready` is registered: it is 1 in EMPTY and ONE and 0 in TWO. It updates on the same edge as the state.
- Accept while in TWO cannot occur, because `in_ready`=0 there.
- Ordering is strictly FIFO: SKID always drains to OUT before any newer entry.
- While `out_valid`=1 and `out_ready`=0, OUT contents and flags are stable.
- `op_count`:
  - Increments by 1 on every accept, including illegal opcodes.
  - Holds at all-ones (0xFFFF at default width) once reached.
  - Cleared only by reset.
- Reset (asynchronous, any time, including mid-transfer):
  - State returns to EMPTY.
  - SKID is discarded.
  - `out_valid`=0, `in_ready`=1, and `result`, all flags and `op_count` are 0.
  - Any in-flight data is lost; there is no replay.

## Timing
- Latency: accept at edge N → `out_valid`=1 with that result after edge N.
- Throughput: 1 transaction per cycle while `out_ready` stays high.
- Single-cycle stall: with `out_ready`=0 for one cycle in ONE, the incoming transaction lands in SKID and `in_ready` falls after that edge. When `out_ready` returns, SKID moves to OUT and `in_ready` rises on the same edge.
- No combinational path from `out_ready` to `in_ready`.
- No combinational path from any input to any output.
- Flags are registered with `result` in the same cycle, never one cycle later.

## Test plan
- Reset and flush:
  - Assert `rst_n`=0 asynchronously mid-cycle while in TWO → `out_valid`=0, `in_ready`=1, `op_count`=0, `result`=0 immediately, without waiting for a clock edge.
  - After release, the first accept shows only the new data.
- Opcode sweep, WIDTH=32, `out_ready`=1, with `and_in`=0x0000_00F0, `or_in`=0xFFFF_00FF, `xor_in`=0x0000_0001, `add_in`=0x0000_0000, `add_cout`=1:
  - AND → 0x000000F0, P=0.
  - OR → 0xFFFF00FF, N=1.
  - XOR → 0x00000001, P=1.
  - NOR → 0x0000FF00.
  - ADD → 0, Z=1, C=1.
  - op 111 → 0, err=1, C=0.
- Back-pressure: stream 4 transactions with `out_ready`=0 from the first accept.
  - Exactly 2 are accepted, and `in_ready`=0 after the second.
  - Raise `out_ready` → all 4 emerge in order with no drops or duplicates.
- Random stall: 1000 random opcodes/operands with random `in_valid`/`out_ready` (~50%) → output sequence matches a reference queue model, and `op_count` equals the number of handshakes.
- Saturation: with CNT_W=4, perform 20 accepts → `op_count` reaches 15 and holds at 15.
- Hold stability: with `out_valid`=1 and `out_ready`=0 for 10 cycles while inputs toggle → `result` and flags are unchanged.
